// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM transaction controller and its account store.
// Optional wrong-PIN lockout in atm_controller is enabled by defining ATM_LOCKOUT_EN.
package atm_pkg;

    localparam int BAL_W_DEF    = 32;
    localparam int PIN_W_DEF    = 16;
    localparam int NUM_ACCOUNTS = 10;

    typedef enum logic [2:0] {
        S_FAIL  = 3'd0,
        S_AUTH  = 3'd1,
        S_DONE  = 3'd2,
        S_BAL   = 3'd3,
        S_WD    = 3'd4,
        S_DEP   = 3'd5,
        S_CHPIN = 3'd6,
        S_IDLE  = 3'd7
    } state_t;

    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_WITHDRAW = 3'd4;
    localparam logic [2:0] OP_DEPOSIT  = 3'd5;
    localparam logic [2:0] OP_CHPIN    = 3'd6;

    localparam logic [BAL_W_DEF-1:0] INIT_BAL [1:NUM_ACCOUNTS] = '{
        32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000,
        32'd6000, 32'd7000, 32'd8000, 32'd9000, 32'd10000
    };

    localparam logic [PIN_W_DEF-1:0] INIT_PIN [1:NUM_ACCOUNTS] = '{
        16'd1234, 16'd2345, 16'd3456, 16'd4567, 16'd5678,
        16'd6789, 16'd7890, 16'd8901, 16'd9012, 16'd7123
    };

    function automatic logic acc_valid(input logic [3:0] acc);
        return (acc >= 4'd1) && (acc <= 4'(NUM_ACCOUNTS));
    endfunction

endpackage

// File: rtl/atm_account_db.sv
// Account register file: combinational read of balance/PIN, one synchronous write port.
// Reset reloads the factory balances and PINs; out-of-range indices read 0 and ignore writes.
module atm_account_db
    import atm_pkg::*;
#(
    parameter int BAL_W = BAL_W_DEF,
    parameter int PIN_W = PIN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       rd_idx_i,
    output logic [BAL_W-1:0] rd_bal_o,
    output logic [PIN_W-1:0] rd_pin_o,
    input  logic             wr_en_i,
    input  logic [3:0]       wr_idx_i,
    input  logic [BAL_W-1:0] wr_bal_i,
    input  logic [PIN_W-1:0] wr_pin_i
);

    logic [BAL_W-1:0] bal_q [1:NUM_ACCOUNTS];
    logic [PIN_W-1:0] pin_q [1:NUM_ACCOUNTS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k <= NUM_ACCOUNTS; k++) begin
                bal_q[k] <= BAL_W'(INIT_BAL[k]);
                pin_q[k] <= PIN_W'(INIT_PIN[k]);
            end
        end else if (wr_en_i && acc_valid(wr_idx_i)) begin
            bal_q[wr_idx_i] <= wr_bal_i;
            pin_q[wr_idx_i] <= wr_pin_i;
        end
    end

    always_comb begin
        rd_bal_o = '0;
        rd_pin_o = '0;
        if (acc_valid(rd_idx_i)) begin
            rd_bal_o = bal_q[rd_idx_i];
            rd_pin_o = pin_q[rd_idx_i];
        end
    end

endmodule

// File: rtl/atm_controller.sv
// ATM transaction FSM: IDLE->AUTH->EXEC->DONE (4 cycles) or IDLE->AUTH->FAIL (3 cycles), no backpressure.
// Define ATM_LOCKOUT_EN to lock an account after three consecutive wrong PINs.
module atm_controller
    import atm_pkg::*;
#(
    parameter int BAL_W = BAL_W_DEF,
    parameter int PIN_W = PIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       operation,
    input  logic [3:0]       acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] newPin,
    input  logic [BAL_W-1:0] amount,
    input  logic             language,
    output logic [BAL_W-1:0] balance,
    output logic             success,
    output logic [2:0]       state
);

    state_t           state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic             success_q, success_d;

    logic [BAL_W-1:0] rd_bal;
    logic [PIN_W-1:0] rd_pin;
    logic             wr_en;
    logic [BAL_W-1:0] wr_bal;
    logic [PIN_W-1:0] wr_pin;

    logic             acc_ok, pin_ok, op_ok, locked, auth_ok;
    logic [BAL_W:0]   dep_sum;
    logic [BAL_W-1:0] wd_diff;

    // Language only steers message text downstream; nothing here depends on it.
    logic unused_language;
    assign unused_language = language;

    atm_account_db #(.BAL_W(BAL_W), .PIN_W(PIN_W)) u_db (
        .clk_i    (clk),
        .rst_i    (rst),
        .rd_idx_i (acc_num),
        .rd_bal_o (rd_bal),
        .rd_pin_o (rd_pin),
        .wr_en_i  (wr_en),
        .wr_idx_i (acc_num),
        .wr_bal_i (wr_bal),
        .wr_pin_i (wr_pin)
    );

    assign acc_ok  = acc_valid(acc_num);
    assign pin_ok  = acc_ok && (pin == rd_pin);
    assign op_ok   = (operation >= OP_BALANCE) && (operation <= OP_CHPIN);
    assign dep_sum = {1'b0, rd_bal} + {1'b0, amount};
    assign wd_diff = rd_bal - amount;

`ifdef ATM_LOCKOUT_EN
    logic [1:0] fail_cnt_q [1:NUM_ACCOUNTS];

    always_comb begin
        locked = 1'b0;
        if (acc_ok) begin
            locked = (fail_cnt_q[acc_num] == 2'd3);
        end
    end

    // Counter saturates at 3 (locked); only reset releases a lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= NUM_ACCOUNTS; k++) begin
                fail_cnt_q[k] <= 2'd0;
            end
        end else if (state_q == S_AUTH && acc_ok) begin
            if (!pin_ok) begin
                if (fail_cnt_q[acc_num] != 2'd3) begin
                    fail_cnt_q[acc_num] <= fail_cnt_q[acc_num] + 2'd1;
                end
            end else if (!locked) begin
                fail_cnt_q[acc_num] <= 2'd0;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

    assign auth_ok = acc_ok && pin_ok && op_ok && !locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            balance_q <= '0;
            success_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            success_q <= success_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        success_d = success_q;
        wr_en     = 1'b0;
        wr_bal    = rd_bal;
        wr_pin    = rd_pin;
        unique case (state_q)
            S_IDLE: begin
                state_d   = S_AUTH;
                success_d = 1'b0;
            end
            S_AUTH: begin
                if (auth_ok) begin
                    state_d = state_t'(operation);
                end else begin
                    state_d   = S_FAIL;
                    balance_d = '0;
                    success_d = 1'b0;
                end
            end
            S_BAL: begin
                state_d   = S_DONE;
                balance_d = rd_bal;
                success_d = 1'b1;
            end
            S_WD: begin
                state_d   = S_DONE;
                balance_d = rd_bal;
                success_d = 1'b0;
                if (amount <= rd_bal) begin
                    wr_en     = 1'b1;
                    wr_bal    = wd_diff;
                    balance_d = wd_diff;
                    success_d = 1'b1;
                end
            end
            S_DEP: begin
                state_d   = S_DONE;
                balance_d = rd_bal;
                success_d = 1'b0;
                if (!dep_sum[BAL_W]) begin
                    wr_en     = 1'b1;
                    wr_bal    = dep_sum[BAL_W-1:0];
                    balance_d = dep_sum[BAL_W-1:0];
                    success_d = 1'b1;
                end
            end
            S_CHPIN: begin
                state_d   = S_DONE;
                balance_d = rd_bal;
                success_d = 1'b0;
                if ((newPin <= PIN_W'(9999)) && (newPin != rd_pin)) begin
                    wr_en     = 1'b1;
                    wr_pin    = newPin;
                    success_d = 1'b1;
                end
            end
            S_FAIL:  state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign balance = balance_q;
    assign success = success_q;
    assign state   = state_q;

endmodule

// File: tb/tb_atm_controller.sv
// Directed bench for atm_controller with an expectation queue popped at the end of each transaction.
module tb_atm_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] newPin;
    logic [31:0] amount;
    logic        language;
    logic [31:0] balance;
    logic        success;
    logic [2:0]  state;

    typedef struct {
        string       tag;
        int          cycles;
        logic [31:0] bal;
        logic        succ;
        logic        failpath;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_bal = 32'd0;

    atm_controller dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .acc_num   (acc_num),
        .pin       (pin),
        .newPin    (newPin),
        .amount    (amount),
        .language  (language),
        .balance   (balance),
        .success   (success),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT in IDLE; returns at the falling edge where it is IDLE again.
    task automatic txn(input string tag, input logic [3:0] a, input logic [15:0] p,
                       input logic [2:0] op, input logic [31:0] amt, input logic [15:0] np,
                       input logic [31:0] eb, input logic es, input logic ef);
        exp_t e;
        int   cyc;
        logic saw_fail;
        logic done;
        e.tag = tag; e.bal = eb; e.succ = es; e.failpath = ef; e.cycles = ef ? 3 : 4;
        sb.push_back(e);
        acc_num = a; pin = p; operation = op; amount = amt; newPin = np;
        language = 1'($urandom_range(0, 1));
        cyc = 0; saw_fail = 1'b0; done = 1'b0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (state == 3'd0) saw_fail = 1'b1;
            if (state == 3'd1) begin
                check({tag, ":auth_succ_clr"}, 32'(success), 32'd0);
                check({tag, ":auth_bal_hold"}, balance, prev_bal);
            end
            if (state == 3'd7) done = 1'b1;
        end
        check({tag, ":finished"}, 32'(done), 32'd1);
        e = sb.pop_front();
        check({e.tag, ":cycles"},  cyc, e.cycles);
        check({e.tag, ":failpath"}, 32'(saw_fail), 32'(e.failpath));
        check({e.tag, ":balance"}, balance, e.bal);
        check({e.tag, ":success"}, 32'(success), 32'(e.succ));
        prev_bal = e.bal;
    endtask

    initial begin
        rst = 1'b1; operation = 3'd0; acc_num = 4'd0; pin = 16'd0;
        newPin = 16'd0; amount = 32'd0; language = 1'b0;
        @(negedge clk);
        check("rst:state",   32'(state), 32'd7);
        check("rst:balance", balance, 32'd0);
        check("rst:success", 32'(success), 32'd0);
        rst = 1'b0;

        txn("bal3",      4'd3, 16'd3456, 3'd3, 32'd0,    16'd0, 32'd3000, 1'b1, 1'b0);
        txn("dep1",      4'd1, 16'd1234, 3'd5, 32'd1000, 16'd0, 32'd2000, 1'b1, 1'b0);
        txn("wd1_500",   4'd1, 16'd1234, 3'd4, 32'd500,  16'd0, 32'd1500, 1'b1, 1'b0);
        txn("wd1_over",  4'd1, 16'd1234, 3'd4, 32'd5000, 16'd0, 32'd1500, 1'b0, 1'b0);
        txn("wd1_zero",  4'd1, 16'd1234, 3'd4, 32'd0,    16'd0, 32'd1500, 1'b1, 1'b0);
        txn("wd1_all",   4'd1, 16'd1234, 3'd4, 32'd1500, 16'd0, 32'd0,    1'b1, 1'b0);
        txn("badpin8",   4'd8, 16'd9012, 3'd4, 32'd100,  16'd0, 32'd0,    1'b0, 1'b1);
        txn("bal8",      4'd8, 16'd8901, 3'd3, 32'd0,    16'd0, 32'd8000, 1'b1, 1'b0);
        txn("chpin10",   4'd10, 16'd7123, 3'd6, 32'd0, 16'd4567, 32'd10000, 1'b1, 1'b0);
        txn("oldpin10",  4'd10, 16'd7123, 3'd3, 32'd0, 16'd0,    32'd0,     1'b0, 1'b1);
        txn("newpin10",  4'd10, 16'd4567, 3'd3, 32'd0, 16'd0,    32'd10000, 1'b1, 1'b0);
        txn("chpin_same",4'd10, 16'd4567, 3'd6, 32'd0, 16'd4567, 32'd10000, 1'b0, 1'b0);
        txn("chpin_big", 4'd10, 16'd4567, 3'd6, 32'd0, 16'd10000, 32'd10000, 1'b0, 1'b0);
        txn("acc0",      4'd0,  16'd1234, 3'd3, 32'd0, 16'd0, 32'd0, 1'b0, 1'b1);
        txn("acc11",     4'd11, 16'd1234, 3'd3, 32'd0, 16'd0, 32'd0, 1'b0, 1'b1);
        txn("op2",       4'd3,  16'd3456, 3'd2, 32'd0, 16'd0, 32'd0, 1'b0, 1'b1);
        txn("op7",       4'd3,  16'd3456, 3'd7, 32'd0, 16'd0, 32'd0, 1'b0, 1'b1);
        txn("dep4_ovf",  4'd4, 16'd4567, 3'd5, 32'hFFFF_F060, 16'd0, 32'd4000,      1'b0, 1'b0);
        txn("dep4_max",  4'd4, 16'd4567, 3'd5, 32'hFFFF_F05F, 16'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        txn("wd4_max",   4'd4, 16'd4567, 3'd4, 32'hFFFF_FFFF, 16'd0, 32'd0,         1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            txn("lock_wrong", 4'd2, 16'd1111, 3'd3, 32'd0, 16'd0, 32'd0, 1'b0, 1'b1);
        end
`ifdef ATM_LOCKOUT_EN
        txn("lock_4th",  4'd2, 16'd2345, 3'd3, 32'd0, 16'd0, 32'd0,    1'b0, 1'b1);
`else
        txn("lock_4th",  4'd2, 16'd2345, 3'd3, 32'd0, 16'd0, 32'd2000, 1'b1, 1'b0);
`endif

        // Reset in the middle of a deposit must abort it and reload the database.
        acc_num = 4'd1; pin = 16'd1234; operation = 3'd5; amount = 32'd1;
        @(negedge clk);
        @(negedge clk);
        check("mid:exec_state", 32'(state), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid:state",   32'(state), 32'd7);
        check("mid:balance", balance, 32'd0);
        check("mid:success", 32'(success), 32'd0);
        prev_bal = 32'd0;

        txn("reload1",   4'd1,  16'd1234, 3'd3, 32'd0, 16'd0, 32'd1000,  1'b1, 1'b0);
        txn("reload10",  4'd10, 16'd7123, 3'd3, 32'd0, 16'd0, 32'd10000, 1'b1, 1'b0);
        txn("unlock2",   4'd2,  16'd2345, 3'd3, 32'd0, 16'd0, 32'd2000,  1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_controller.md
Name: atm_controller

Overview:
- Transaction controller for an ATM holding an internal 10-account database of balances and PINs.
- Each transaction is one 4-cycle pass: authenticate account number and PIN, execute the requested operation (balance, withdraw, deposit, change PIN), report result, return to idle.
- Sits between the user-input front end and the display/result logic.

Parameters:
- BAL_W, 32, width of balances and amount.
- PIN_W, 16, width of PINs (binary value of the 4-digit decimal PIN).
- NUM_ACCOUNTS, 10, number of accounts, indexed 1..NUM_ACCOUNTS; must be <= 15.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- operation  in  3  3=balance inquiry, 4=withdraw, 5=deposit, 6=change PIN; other codes are invalid.
- acc_num  in  4  account number, valid range 1..NUM_ACCOUNTS.
- pin  in  PIN_W  entered PIN.
- newPin  in  PIN_W  replacement PIN for operation 6.
- amount  in  BAL_W  withdraw/deposit amount, unsigned.
- language  in  1  0=English, 1=Arabic; message selection only, no datapath effect.
- balance  out  BAL_W  registered balance of the transacted account.
- success  out  1  registered pass/fail of the last transaction.
- state  out  3  current FSM state encoding.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=7 (IDLE), balance=0, success=0.
  - Database reloads to balance[k]=k*1000 for k=1..10.
  - PINs reload to 1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123 for accounts 1..10.
  - Reset dominates every state.
- FSM encoding: IDLE=7, AUTH=1, EXEC=3..6 (state equals the operation code), FAIL=0, DONE=2.
- Transitions (inputs sampled each edge, held stable by the user for the whole transaction):
  - IDLE -> AUTH.
  - AUTH -> EXEC(operation) if acc_num is in 1..NUM_ACCOUNTS, pin equals the stored PIN, and operation is in 3..6; otherwise AUTH -> FAIL.
  - EXEC -> DONE.
  - FAIL -> IDLE.
  - DONE -> IDLE.
- A passing transaction takes 4 cycles; a failed one takes 3 cycles and idles one extra cycle if the user waits 4.
- On entering AUTH: success cleared to 0.
- EXEC results, registered on the EXEC->DONE edge:
  - 3 (balance): balance <= stored balance; success=1.
  - 4 (withdraw): if amount <= stored balance, stored -= amount, balance <= new value, success=1. Otherwise no change, balance <= stored, success=0. amount=0 is legal.
  - 5 (deposit): if stored+amount fits in BAL_W, stored += amount, balance <= new value, success=1. On overflow, no change and success=0.
  - 6 (change PIN): if newPin <= 9999 and newPin != current PIN, the stored PIN is replaced, balance <= stored balance, success=1. Otherwise no change, success=0.
- FAIL: balance <= 0, success <= 0.
- Outputs hold their value through IDLE until the next AUTH, which clears success only.
- Arithmetic is unsigned BAL_W. Overflow detection uses a BAL_W+1 sum.

Optional Feature:
- Macro ATM_LOCKOUT_EN.
- With it defined:
  - Per-account 2-bit wrong-PIN counter.
  - 3 consecutive wrong PINs lock the account; later AUTH on a locked account goes to FAIL even with the correct PIN.
  - A correct PIN on an unlocked account clears its counter.
  - Locks and counters clear only on rst.
- Without it: no counters, unlimited retries.

Decomposition:
- Package atm_pkg holds:
  - state enum (IDLE=7, AUTH=1, FAIL=0, DONE=2, EXEC codes 3..6);
  - operation code constants OP_BALANCE=3, OP_WITHDRAW=4, OP_DEPOSIT=5, OP_CHPIN=6;
  - NUM_ACCOUNTS;
  - initial-balance and initial-PIN constant arrays.
- One sub-module, atm_account_db: register-file storage of balances and PINs, with synchronous reset-to-defaults and one write port for balance/PIN.
- FSM and arithmetic stay in the top module.

Test Plan:
- Reset: rst=1 for one edge -> state=7, balance=0, success=0.
- Balance: acc_num=3, pin=3456, operation=3, held 4 cycles -> balance=3000, success=1.
- Deposit then withdraw:
  - acc_num=1, pin=1234, op=5, amount=1000 -> balance=2000;
  - then op=4, amount=500 -> balance=1500, success=1;
  - then op=4, amount=5000 -> balance=1500, success=0.
- Wrong PIN: acc_num=8, pin=9012, op=4 -> state passes through 0, balance=0, success=0, stored balance unchanged.
- Change PIN:
  - acc_num=10, pin=7123, op=6, newPin=4567 -> success=1;
  - next op=3 with pin=7123 fails; op=3 with pin=4567 gives balance=10000.
- Invalid account/op: acc_num=0 or 11, or operation=2 -> FAIL, success=0. Under ATM_LOCKOUT_EN, a 4th attempt on acc 2 with correct pin 2345 after 3 wrong PINs -> success=0.
